// File: rtl/apb_axi_bridge_mc_if.sv
`default_nettype none
// =============================================================================
// apb_axi_bridge_mc_if : APB slave + multi-port AXI4 master signal bundle
// Rev 1.0
// =============================================================================
interface apb_axi_bridge_mc_if #(
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DRAM_NUMBER = 2
);
  logic [ADDR_WIDTH-1:0]             PADDR;
  logic [DATA_WIDTH-1:0]             PWDATA;
  logic                              PSELx;
  logic                              PENABLE;
  logic                              PWRITE;
  logic [DATA_WIDTH-1:0]             PRDATA;
  logic                              PREADY;
  logic                              PSLVERR;

  logic [DRAM_NUMBER*ID_WIDTH-1:0]   arid_m_inf;
  logic [DRAM_NUMBER*ADDR_WIDTH-1:0] araddr_m_inf;
  logic [DRAM_NUMBER*4-1:0]          arlen_m_inf;
  logic [DRAM_NUMBER*3-1:0]          arsize_m_inf;
  logic [DRAM_NUMBER*2-1:0]          arburst_m_inf;
  logic [DRAM_NUMBER-1:0]            arvalid_m_inf;
  logic [DRAM_NUMBER-1:0]            arready_m_inf;

  logic [DRAM_NUMBER*ID_WIDTH-1:0]   rid_m_inf;
  logic [DRAM_NUMBER*DATA_WIDTH-1:0] rdata_m_inf;
  logic [DRAM_NUMBER*2-1:0]          rresp_m_inf;
  logic [DRAM_NUMBER-1:0]            rlast_m_inf;
  logic [DRAM_NUMBER-1:0]            rvalid_m_inf;
  logic [DRAM_NUMBER-1:0]            rready_m_inf;

  logic [ID_WIDTH-1:0]               awid_m_inf;
  logic [ADDR_WIDTH-1:0]             awaddr_m_inf;
  logic [2:0]                        awsize_m_inf;
  logic [1:0]                        awburst_m_inf;
  logic [3:0]                        awlen_m_inf;
  logic                              awvalid_m_inf;
  logic                              awready_m_inf;

  logic [DATA_WIDTH-1:0]             wdata_m_inf;
  logic                              wlast_m_inf;
  logic                              wvalid_m_inf;
  logic                              wready_m_inf;

  logic [ID_WIDTH-1:0]               bid_m_inf;
  logic [1:0]                        bresp_m_inf;
  logic                              bvalid_m_inf;
  logic                              bready_m_inf;

  // Bridge side: APB slave, AXI master
  modport slave (
    input  PADDR, PWDATA, PSELx, PENABLE, PWRITE,
    output PRDATA, PREADY, PSLVERR,
    output arid_m_inf, araddr_m_inf, arlen_m_inf, arsize_m_inf, arburst_m_inf, arvalid_m_inf,
    input  arready_m_inf,
    input  rid_m_inf, rdata_m_inf, rresp_m_inf, rlast_m_inf, rvalid_m_inf,
    output rready_m_inf,
    output awid_m_inf, awaddr_m_inf, awsize_m_inf, awburst_m_inf, awlen_m_inf, awvalid_m_inf,
    input  awready_m_inf,
    output wdata_m_inf, wlast_m_inf, wvalid_m_inf,
    input  wready_m_inf,
    input  bid_m_inf, bresp_m_inf, bvalid_m_inf,
    output bready_m_inf
  );

  // Environment side: APB host plus AXI slaves
  modport master (
    output PADDR, PWDATA, PSELx, PENABLE, PWRITE,
    input  PRDATA, PREADY, PSLVERR,
    input  arid_m_inf, araddr_m_inf, arlen_m_inf, arsize_m_inf, arburst_m_inf, arvalid_m_inf,
    output arready_m_inf,
    output rid_m_inf, rdata_m_inf, rresp_m_inf, rlast_m_inf, rvalid_m_inf,
    input  rready_m_inf,
    input  awid_m_inf, awaddr_m_inf, awsize_m_inf, awburst_m_inf, awlen_m_inf, awvalid_m_inf,
    output awready_m_inf,
    input  wdata_m_inf, wlast_m_inf, wvalid_m_inf,
    output wready_m_inf,
    output bid_m_inf, bresp_m_inf, bvalid_m_inf,
    input  bready_m_inf
  );
endinterface
`default_nettype wire

// File: rtl/apb_axi_bridge_mc.sv
`default_nettype none
// =============================================================================
// apb_axi_bridge_mc : APB slave to AXI4 master bridge, N read ports, 1 write port
// Rev 1.0
// =============================================================================
module apb_axi_bridge_mc #(
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DRAM_NUMBER = 2,
  parameter int SEL_LSB     = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  apb_axi_bridge_mc_if.slave bus
);
  localparam int             CW     = (DRAM_NUMBER > 1) ? $clog2(DRAM_NUMBER) : 1;
  localparam logic [CW:0]    NPORTS = (CW+1)'(DRAM_NUMBER);
  localparam logic [2:0]     AXSIZE = 3'($clog2(DATA_WIDTH/8));

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    W    = 3'd3,
    B    = 3'd4,
    RESP = 3'd5
  } state_t;

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_nx;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_nx;
  logic [DATA_WIDTH-1:0]   data_q, data_nx;
  logic [CW-1:0]           ch_q, ch_nx;
  logic                    err_q, err_nx;
  logic                    aw_done, aw_done_nx;
  logic                    w_done, w_done_nx;
  logic                    pready_q, pready_nx;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_nx;
  logic                    pslverr_q, pslverr_nx;
  logic                    respond;

  logic                    arready_sel, rvalid_sel, rlast_sel;
  logic [1:0]              rresp_sel;
  logic [ID_WIDTH-1:0]     rid_sel;
  logic [DATA_WIDTH-1:0]   rdata_sel;
  logic                    unused_bid;

  assign unused_bid = ^bus.bid_m_inf;

  // Only the latched channel is ever looked at; other ports are don't-care
  always_comb begin
    arready_sel = 1'b0;
    rvalid_sel  = 1'b0;
    rlast_sel   = 1'b0;
    rresp_sel   = '0;
    rid_sel     = '0;
    rdata_sel   = '0;
    for (int k = 0; k < DRAM_NUMBER; k++) begin
      if (ch_q == CW'(k)) begin
        arready_sel = bus.arready_m_inf[k];
        rvalid_sel  = bus.rvalid_m_inf[k];
        rlast_sel   = bus.rlast_m_inf[k];
        rresp_sel   = bus.rresp_m_inf[k*2 +: 2];
        rid_sel     = bus.rid_m_inf[k*ID_WIDTH +: ID_WIDTH];
        rdata_sel   = bus.rdata_m_inf[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_nx   = state;
    addr_nx    = addr_q;
    wdata_nx   = wdata_q;
    data_nx    = data_q;
    ch_nx      = ch_q;
    err_nx     = err_q;
    aw_done_nx = aw_done;
    w_done_nx  = w_done;
    respond    = 1'b0;
    pready_nx  = 1'b0;
    prdata_nx  = '0;
    pslverr_nx = 1'b0;
    case (state)
      IDLE: begin
        if (bus.PSELx && !bus.PENABLE) begin
          addr_nx    = bus.PADDR;
          wdata_nx   = bus.PWDATA;
          ch_nx      = bus.PADDR[SEL_LSB +: CW];
          data_nx    = '0;
          err_nx     = 1'b0;
          aw_done_nx = 1'b0;
          w_done_nx  = 1'b0;
          if (bus.PWRITE) begin
            state_nx = W;
          end else if ({1'b0, ch_nx} < NPORTS) begin
            state_nx = AR;
          end else begin
            state_nx = RESP;
            err_nx   = 1'b1;
          end
        end
      end
      AR: begin
        if (arready_sel) state_nx = R;
      end
      R: begin
        if (rvalid_sel) begin
          data_nx  = rdata_sel;
          err_nx   = (rresp_sel != 2'b00) || (rid_sel != ID_WIDTH'(ch_q)) || !rlast_sel;
          state_nx = RESP;
          respond  = 1'b1;
        end
      end
      W: begin
        aw_done_nx = aw_done | bus.awready_m_inf;
        w_done_nx  = w_done  | bus.wready_m_inf;
        if (aw_done_nx && w_done_nx) state_nx = B;
      end
      B: begin
        if (bus.bvalid_m_inf) begin
          err_nx   = (bus.bresp_m_inf != 2'b00);
          state_nx = RESP;
          respond  = 1'b1;
        end
      end
      RESP: begin
        if (pready_q) state_nx = IDLE;
        else          respond  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    // Completion can be signalled on the same edge the AXI response lands,
    // which is what keeps the minimum APB latency at three cycles.
    if (respond && bus.PSELx && bus.PENABLE) begin
      pready_nx  = 1'b1;
      prdata_nx  = data_nx;
      pslverr_nx = err_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_q    <= '0;
      ch_q      <= '0;
      err_q     <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state     <= state_nx;
      addr_q    <= addr_nx;
      wdata_q   <= wdata_nx;
      data_q    <= data_nx;
      ch_q      <= ch_nx;
      err_q     <= err_nx;
      aw_done   <= aw_done_nx;
      w_done    <= w_done_nx;
      pready_q  <= pready_nx;
      prdata_q  <= prdata_nx;
      pslverr_q <= pslverr_nx;
    end
  end

  assign bus.PREADY  = pready_q;
  assign bus.PRDATA  = prdata_q;
  assign bus.PSLVERR = pslverr_q;

  for (genvar k = 0; k < DRAM_NUMBER; k++) begin : g_rd_port
    localparam logic [CW-1:0] K = CW'(k);
    assign bus.arid_m_inf[k*ID_WIDTH +: ID_WIDTH]       = ID_WIDTH'(k);
    assign bus.araddr_m_inf[k*ADDR_WIDTH +: ADDR_WIDTH] = (ch_q == K) ? addr_q : '0;
    assign bus.arlen_m_inf[k*4 +: 4]                    = 4'd0;
    assign bus.arsize_m_inf[k*3 +: 3]                   = AXSIZE;
    assign bus.arburst_m_inf[k*2 +: 2]                  = 2'b01;
    assign bus.arvalid_m_inf[k]                         = (state == AR) && (ch_q == K);
    assign bus.rready_m_inf[k]                          = (state == R)  && (ch_q == K);
  end

  assign bus.awid_m_inf    = '0;
  assign bus.awaddr_m_inf  = addr_q;
  assign bus.awsize_m_inf  = AXSIZE;
  assign bus.awburst_m_inf = 2'b01;
  assign bus.awlen_m_inf   = 4'd0;
  assign bus.awvalid_m_inf = (state == W) && !aw_done;
  assign bus.wdata_m_inf   = wdata_q;
  assign bus.wvalid_m_inf  = (state == W) && !w_done;
  assign bus.wlast_m_inf   = bus.wvalid_m_inf;
  assign bus.bready_m_inf  = (state == B);

endmodule
`default_nettype wire

// File: tb/tb_apb_axi_bridge_mc.sv
`default_nettype none
// =============================================================================
// tb_apb_axi_bridge_mc : directed self-checking bench, 3 read ports
// Rev 1.0
// =============================================================================
module tb_apb_axi_bridge_mc;
  localparam int IW = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DN = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  apb_axi_bridge_mc_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DRAM_NUMBER(DN)) bus ();

  apb_axi_bridge_mc #(
    .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DRAM_NUMBER(DN), .SEL_LSB(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_slaves();
    bus.arready_m_inf = '0;
    bus.rvalid_m_inf  = '0;
    bus.rid_m_inf     = '0;
    bus.rdata_m_inf   = '0;
    bus.rresp_m_inf   = '0;
    bus.rlast_m_inf   = '0;
    bus.awready_m_inf = 1'b0;
    bus.wready_m_inf  = 1'b0;
    bus.bvalid_m_inf  = 1'b0;
    bus.bresp_m_inf   = '0;
    bus.bid_m_inf     = '0;
  endtask

  task automatic apb_setup(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic wr);
    bus.PADDR   = a;
    bus.PWDATA  = d;
    bus.PWRITE  = wr;
    bus.PSELx   = 1'b1;
    bus.PENABLE = 1'b0;
  endtask

  task automatic end_apb();
    bus.PSELx   = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic drive_r(input int p, input logic [DW-1:0] d, input logic [1:0] resp,
                         input logic [IW-1:0] id, input logic last);
    bus.rvalid_m_inf[p]            = 1'b1;
    bus.rdata_m_inf[p*DW +: DW]    = d;
    bus.rresp_m_inf[p*2 +: 2]      = resp;
    bus.rid_m_inf[p*IW +: IW]      = id;
    bus.rlast_m_inf[p]             = last;
  endtask

  // Zero-wait read: setup at c0, arready at c1, rvalid at c2, PREADY at c3
  task automatic read_zw(input string tag, input int p, input logic [DW-1:0] d,
                         input logic [1:0] resp);
    logic [DN-1:0] onehot;
    onehot = DN'(1) << p;
    apb_setup(AW'(p) << 16 | 32'h0000_0080, '0, 1'b0);
    sb.push_back('{data: d, err: (resp != 2'b00)});
    step();
    bus.PENABLE = 1'b1;
    chk({tag, "_arvalid"}, bus.arvalid_m_inf, onehot);
    bus.arready_m_inf[p] = 1'b1;
    step();
    bus.arready_m_inf = '0;
    chk({tag, "_rready"}, bus.rready_m_inf, onehot);
    chk({tag, "_arvalid_off"}, bus.arvalid_m_inf, '0);
    drive_r(p, d, resp, IW'(p), 1'b1);
    step();
    clear_slaves();
    chk({tag, "_pready_c3"}, bus.PREADY, 1'b1);
    step();
    end_apb();
    chk({tag, "_pready_drop"}, bus.PREADY, 1'b0);
  endtask

  // Completion monitor: every PREADY must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.PREADY) begin
        if (sb.size() == 0) begin
          chk("unexpected_pready", bus.PREADY, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("prdata", bus.PRDATA, e.data);
          chk("pslverr", bus.PSLVERR, e.err);
        end
      end else begin
        chk("idle_resp_zero", {bus.PRDATA, bus.PSLVERR}, '0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    end_apb();
    bus.PADDR  = '0;
    bus.PWDATA = '0;
    bus.PWRITE = 1'b0;
    clear_slaves();
    step();
    step();
    chk("rst_arvalid", bus.arvalid_m_inf, '0);
    chk("rst_rready", bus.rready_m_inf, '0);
    chk("rst_aw_w_b", {bus.awvalid_m_inf, bus.wvalid_m_inf, bus.bready_m_inf}, '0);
    chk("rst_apb", {bus.PREADY, bus.PSLVERR, bus.PRDATA}, '0);
    rst_n = 1'b1;
    step();

    // Read channel 1 with a slow arready and junk on port 0
    apb_setup(32'h0001_0040, '0, 1'b0);
    sb.push_back('{data: 32'hDEAD_BEEF, err: 1'b0});
    step();
    bus.PENABLE = 1'b1;
    chk("t1_arvalid", bus.arvalid_m_inf, 3'b010);
    chk("t1_araddr1", bus.araddr_m_inf[AW +: AW], 32'h0001_0040);
    chk("t1_arid1", bus.arid_m_inf[IW +: IW], 4'd1);
    chk("t1_ar_const", {bus.arlen_m_inf[4 +: 4], bus.arsize_m_inf[3 +: 3], bus.arburst_m_inf[2 +: 2]},
        {4'd0, 3'd2, 2'b01});
    step();
    chk("t1_arvalid_hold", bus.arvalid_m_inf, 3'b010);
    step();
    bus.arready_m_inf[1] = 1'b1;
    step();
    bus.arready_m_inf = '0;
    chk("t1_rready", bus.rready_m_inf, 3'b010);
    drive_r(0, 32'h0BAD_0BAD, 2'b11, 4'd0, 1'b1);
    drive_r(1, 32'hDEAD_BEEF, 2'b00, 4'd1, 1'b1);
    step();
    clear_slaves();
    chk("t1_pready", bus.PREADY, 1'b1);
    step();
    end_apb();
    chk("t1_pready_one", bus.PREADY, 1'b0);

    // Write with wready three cycles ahead of awready
    apb_setup(32'h0000_0100, 32'h1234_5678, 1'b1);
    sb.push_back('{data: '0, err: 1'b0});
    step();
    bus.PENABLE = 1'b1;
    chk("t2_aw_w_valid", {bus.awvalid_m_inf, bus.wvalid_m_inf, bus.wlast_m_inf}, 3'b111);
    chk("t2_awaddr", bus.awaddr_m_inf, 32'h0000_0100);
    chk("t2_wdata", bus.wdata_m_inf, 32'h1234_5678);
    chk("t2_aw_const", {bus.awid_m_inf, bus.awlen_m_inf, bus.awsize_m_inf, bus.awburst_m_inf},
        {4'd0, 4'd0, 3'd2, 2'b01});
    bus.wready_m_inf = 1'b1;
    step();
    bus.wready_m_inf = 1'b0;
    chk("t2_w_first", {bus.awvalid_m_inf, bus.wvalid_m_inf}, 2'b10);
    step();
    step();
    chk("t2_aw_hold", {bus.awvalid_m_inf, bus.bready_m_inf}, 2'b10);
    bus.awready_m_inf = 1'b1;
    step();
    bus.awready_m_inf = 1'b0;
    chk("t2_b_phase", {bus.awvalid_m_inf, bus.wvalid_m_inf, bus.bready_m_inf}, 3'b001);
    bus.bvalid_m_inf = 1'b1;
    step();
    clear_slaves();
    chk("t2_pready", bus.PREADY, 1'b1);
    step();
    end_apb();

    // Error responses: SLVERR read on ch0, DECERR write
    read_zw("t3_rd", 0, 32'hCAFE_0001, 2'b10);
    apb_setup(32'h0000_0200, 32'h5555_AAAA, 1'b1);
    sb.push_back('{data: '0, err: 1'b1});
    step();
    bus.PENABLE       = 1'b1;
    bus.awready_m_inf = 1'b1;
    bus.wready_m_inf  = 1'b1;
    step();
    bus.awready_m_inf = 1'b0;
    bus.wready_m_inf  = 1'b0;
    bus.bvalid_m_inf  = 1'b1;
    bus.bresp_m_inf   = 2'b11;
    step();
    clear_slaves();
    chk("t3_wr_pready", bus.PREADY, 1'b1);
    step();
    end_apb();

    // Out-of-range channel select
    apb_setup(32'h0003_0000, '0, 1'b0);
    sb.push_back('{data: '0, err: 1'b1});
    step();
    bus.PENABLE = 1'b1;
    chk("t4_no_arvalid", bus.arvalid_m_inf, '0);
    step();
    chk("t4_no_arvalid2", bus.arvalid_m_inf, '0);
    chk("t4_pready_c2", bus.PREADY, 1'b1);
    step();
    end_apb();

    // Reset while a read response is pending
    apb_setup(32'h0001_0000, '0, 1'b0);
    step();
    bus.PENABLE = 1'b1;
    bus.arready_m_inf[1] = 1'b1;
    step();
    bus.arready_m_inf = '0;
    chk("t5_rready", bus.rready_m_inf, 3'b010);
    drive_r(1, 32'h7777_7777, 2'b00, 4'd1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_clear", {bus.arvalid_m_inf, bus.rready_m_inf, bus.awvalid_m_inf,
                           bus.wvalid_m_inf, bus.bready_m_inf, bus.PREADY}, '0);
    end_apb();
    clear_slaves();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("t5_stay_idle", {bus.rready_m_inf, bus.arvalid_m_inf, bus.PREADY}, '0);
    read_zw("t5_after", 2, 32'h0123_4567, 2'b00);

    // Back-to-back zero-wait reads
    read_zw("t6_ch0", 0, 32'hA5A5_0000, 2'b00);
    read_zw("t6_ch1", 1, 32'h5A5A_1111, 2'b00);
    step();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
